dram_readback_packer: RTL and testbench

- Read-side companion for a 256x1 dual-port distributed RAM (RAM256X1D-style).
- The write port stays owned by the existing logic. This block drives only the DPRA address and samples the asynchronous DPO output.
- It walks a run of consecutive bit addresses, packs every 8 bits LSB-first into a byte, and presents each byte on a valid/ready stream.
- Used for readback and self-check of distributed-RAM contents in the test designs.

---
 rtl/dram_readback_packer_if.sv | 27 ++
 rtl/dram_readback_packer.sv | 111 +++++++++++
 tb/tb_dram_readback_packer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_readback_packer_if.sv
// Control, RAM read-port and byte-stream signals of the distributed-RAM readback packer.
// slave = the packer itself; master = whoever drives start/dpo/m_ready.
interface dram_readback_packer_if #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8,
  parameter int LEN_W  = 6
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] dpra;
  logic              dpo;
  logic [BYTE_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, len, dpo, m_ready,
    output dpra, m_data, m_valid, busy, done
  );
  modport master (
    output start, base_addr, len, dpo, m_ready,
    input  dpra, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/dram_readback_packer.sv
// Walks consecutive bit addresses of a 256x1 distributed RAM via DPRA/DPO and
// packs every BYTE_W bits LSB-first into bytes on a valid/ready stream.
module dram_readback_packer #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8,
  parameter int LEN_W  = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  dram_readback_packer_if.slave bus
);
  localparam int CNT_W = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] dpra_q, dpra_nx;
  logic [BYTE_W-1:0] shreg_q, shreg_nx;
  logic [BYTE_W-1:0] data_q, data_nx;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_nx;
  logic [LEN_W-1:0]  left_q, left_nx;
  logic              valid_q, valid_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dpra_q    <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      left_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      dpra_q    <= dpra_nx;
      shreg_q   <= shreg_nx;
      data_q    <= data_nx;
      bit_cnt_q <= bit_cnt_nx;
      left_q    <= left_nx;
      valid_q   <= valid_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state_q;
    dpra_nx    = dpra_q;
    shreg_nx   = shreg_q;
    data_nx    = data_q;
    bit_cnt_nx = bit_cnt_q;
    left_nx    = left_q;
    valid_nx   = valid_q;
    busy_nx    = busy_q;
    done_nx    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          left_nx    = bus.len;
          dpra_nx    = bus.base_addr;
          busy_nx    = 1'b1;
          bit_cnt_nx = '0;
          state_nx   = FETCH;
        end
      end
      FETCH: begin
        // a zero-length request passes through FETCH once just to retire with done
        if (left_q == '0) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          shreg_nx[bit_cnt_q] = bus.dpo;
          dpra_nx             = dpra_q + 1'b1;
          bit_cnt_nx          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            data_nx    = {bus.dpo, shreg_q[BYTE_W-2:0]};
            valid_nx   = 1'b1;
            bit_cnt_nx = '0;
            state_nx   = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          valid_nx = 1'b0;
          left_nx  = left_q - 1'b1;
          if (left_q == LEN_W'(1)) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dpra    = dpra_q;
  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_dram_readback_packer.sv
// Bench for dram_readback_packer: behavioural 256x1 RAM, directed scenarios and
// randomized runs checked against a byte model built straight from RAM contents.
module tb_dram_readback_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_readback_packer_if #(.ADDR_W(8), .BYTE_W(8), .LEN_W(6)) bus ();
  dram_readback_packer #(.ADDR_W(8), .BYTE_W(8), .LEN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic mem [0:255];
  assign bus.dpo = mem[bus.dpra];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got_q [$];
  int done_cnt, done_cyc, overlap;

  task automatic mem_init();
    for (int i = 0; i < 256; i++) mem[i] = (i == 1);
  endtask

  task automatic mem_put_byte(input int addr, input logic [7:0] b);
    for (int i = 0; i < 8; i++) mem[(addr + i) % 256] = b[i];
  endtask

  function automatic logic [7:0] ref_byte(input int base, input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = mem[(base + 8 * k + i) % 256];
    return r;
  endfunction

  // Drives one run, randomly stalling m_ready, and records accepted bytes and done pulses.
  task automatic run_collect(input logic [7:0] base, input logic [5:0] ln, input int stall_pct);
    int tail;
    tail = -1;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; overlap = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.len = ln; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < int'(ln) * 40 + 20 && tail != 0; c++) begin
      if (bus.done) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
        if (tail < 0) tail = 5;
      end
      if (bus.done && bus.m_valid) overlap++;
      bus.m_ready = ($urandom_range(99) >= stall_pct);
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      if (tail > 0) tail--;
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL reset_flags valid=%b busy=%b done=%b want 000", bus.m_valid, bus.busy, bus.done); end
    n_cmp++; if (bus.dpra !== 8'h00 || bus.m_data !== 8'h00) begin
      n_err++; $display("FAIL reset_regs dpra=%h data=%h want 00/00", bus.dpra, bus.m_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.dpra !== 8'h00) begin
      n_err++; $display("FAIL post_reset_idle busy=%b valid=%b dpra=%h", bus.busy, bus.m_valid, bus.dpra); end
  endtask

  task automatic test_basic();
    mem_init();
    bus.m_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 6'd1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++; if (bus.dpra !== 8'(k)) begin
        n_err++; $display("FAIL basic_dpra k=%0d got %h want %h", k, bus.dpra, 8'(k)); end
      n_cmp++; if (bus.m_valid !== (k == 8)) begin
        n_err++; $display("FAIL basic_valid k=%0d got %b want %b", k, bus.m_valid, (k == 8)); end
      if (k < 8) @(negedge clk);
    end
    n_cmp++; if (bus.m_data !== 8'h02) begin
      n_err++; $display("FAIL basic_data got %h want 02", bus.m_data); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done done=%b valid=%b busy=%b want 1/0/0", bus.done, bus.m_valid, bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_wrap();
    mem_init();
    for (int a = 252; a < 256; a++) mem[a] = 1'b1;
    for (int a = 0; a < 4; a++) mem[a] = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.base_addr = 8'hFC; bus.len = 6'd1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++; if (bus.dpra !== 8'(252 + k)) begin
        n_err++; $display("FAIL wrap_dpra k=%0d got %h want %h", k, bus.dpra, 8'(252 + k)); end
      if (k < 8) @(negedge clk);
    end
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h0F) begin
      n_err++; $display("FAIL wrap_data valid=%b data=%h want 1/0F", bus.m_valid, bus.m_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int first_j, extra_done;
    mem_init();
    mem_put_byte(16, 8'hA5);
    mem_put_byte(24, 8'h3C);
    bus.m_ready = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.base_addr = 8'h10; bus.len = 6'd2;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5) begin
      n_err++; $display("FAIL bp_first valid=%b data=%h want 1/A5", bus.m_valid, bus.m_data); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || bus.done !== 1'b0) begin
        n_err++; $display("FAIL bp_hold s=%0d valid=%b data=%h done=%b", s, bus.m_valid, bus.m_data, bus.done); end
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL bp_accept valid=%b done=%b want 0/0", bus.m_valid, bus.done); end
    first_j = -1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (bus.m_valid && first_j < 0) first_j = j;
    end
    n_cmp++; if (first_j !== 8 || bus.m_data !== 8'h3C) begin
      n_err++; $display("FAIL bp_second first_valid=%0d data=%h want 8/3C", first_j, bus.m_data); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL bp_done done=%b busy=%b want 1/0", bus.done, bus.busy); end
    extra_done = 0;
    repeat (5) begin @(negedge clk); if (bus.done) extra_done++; end
    n_cmp++; if (extra_done !== 0) begin
      n_err++; $display("FAIL bp_single_done extra=%0d want 0", extra_done); end
  endtask

  task automatic test_zero_len();
    mem_init();
    run_collect(8'h20, 6'd0, 0);
    n_cmp++; if (done_cyc !== 1 || done_cnt !== 1) begin
      n_err++; $display("FAIL zero_done cyc=%0d cnt=%0d want 1/1", done_cyc, done_cnt); end
    n_cmp++; if (got_q.size() !== 0) begin
      n_err++; $display("FAIL zero_bytes got %0d want 0", got_q.size()); end
  endtask

  task automatic test_busy_reject();
    int nbytes, ndone;
    logic [7:0] first;
    mem_init();
    nbytes = 0; ndone = 0; first = 8'h00;
    bus.m_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 6'd1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.m_valid && bus.m_ready) begin
        if (nbytes == 0) first = bus.m_data;
        nbytes++;
      end
      if (bus.done) ndone++;
      bus.start = (k == 3);
      bus.base_addr = (k == 3) ? 8'h80 : 8'h00;
      bus.len = (k == 3) ? 6'd5 : 6'd1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_cmp++; if (nbytes !== 1 || first !== 8'h02) begin
      n_err++; $display("FAIL busy_reject_bytes n=%0d first=%h want 1/02", nbytes, first); end
    n_cmp++; if (ndone !== 1) begin
      n_err++; $display("FAIL busy_reject_done n=%0d want 1", ndone); end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    mem_init();
    bus.m_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 6'd1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dpra !== 8'h00) begin
      n_err++; $display("FAIL midrst_async valid=%b busy=%b dpra=%h want 0/0/00", bus.m_valid, bus.busy, bus.dpra); end
    ndone = 0;
    repeat (3) begin @(negedge clk); if (bus.done) ndone++; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (bus.done || bus.busy || bus.m_valid) ndone++; end
    n_cmp++; if (ndone !== 0) begin
      n_err++; $display("FAIL midrst_quiet activity=%0d want 0", ndone); end
    run_collect(8'h00, 6'd1, 0);
    n_cmp++; if (got_q.size() !== 1 || done_cnt !== 1) begin
      n_err++; $display("FAIL midrst_rerun bytes=%0d done=%0d want 1/1", got_q.size(), done_cnt); end
    else begin
      n_cmp++; if (got_q[0] !== 8'h02) begin
        n_err++; $display("FAIL midrst_data got %h want 02", got_q[0]); end
    end
  endtask

  task automatic test_random();
    int base, ln, stall;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 1'($urandom);
      base  = $urandom_range(255);
      ln    = (r == 0) ? 40 : $urandom_range(36, 1);
      stall = (r < 2) ? 0 : 30;
      run_collect(8'(base), 6'(ln), stall);
      n_cmp++; if (done_cnt !== 1 || overlap !== 0) begin
        n_err++; $display("FAIL rand%0d_done cnt=%0d overlap=%0d want 1/0", r, done_cnt, overlap); end
      n_cmp++; if (got_q.size() !== ln) begin
        n_err++; $display("FAIL rand%0d_count got %0d want %0d", r, got_q.size(), ln); end
      for (int k = 0; k < ln && k < got_q.size(); k++) begin
        n_cmp++; if (got_q[k] !== ref_byte(base, k)) begin
          n_err++; $display("FAIL rand%0d_byte%0d base=%h got %h want %h", r, k, base, got_q[k], ref_byte(base, k)); end
      end
      if (stall == 0) begin
        n_cmp++; if (done_cyc !== 9 * ln) begin
          n_err++; $display("FAIL rand%0d_rate done_cyc=%0d want %0d", r, done_cyc, 9 * ln); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b1;
    mem_init();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_busy_reject();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end
endmodule
